// File: rtl/fft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared types and constants for the FFT frame sequencer.
//   fft_ctrl_state_t : sequencer FSM encoding (IDLE, STREAM, FLUSH, DRAIN)
//   FFT_BEATS        : default beats per frame
//   FFT_FLUSH        : default zero beats used to drain the delay lines
//   FFT_WDOG         : default DRAIN watchdog limit in cycles
//   cnt_width()      : counter width able to hold values 0 .. n-1 (min 1 bit)
// -----------------------------------------------------------------------------
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } fft_ctrl_state_t;

    localparam int FFT_BEATS = 32;
    localparam int FFT_FLUSH = 32;
    localparam int FFT_WDOG  = 1023;

    // Width of a counter that runs 0 .. n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        if (n > 2) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// -----------------------------------------------------------------------------
// fft_beat_counter
// Modulo-MAX wrap counter used for the input and output beat positions.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clr   : synchronous clear to 0 (takes priority over inc)
//   inc   : advance by one, wrapping MAX-1 -> 0
//   count : current beat position
//   wrap  : high in the cycle an increment takes the counter from MAX-1 to 0
// -----------------------------------------------------------------------------
module fft_beat_counter
    import fft_ctrl_pkg::*;
#(
    parameter int MAX = FFT_BEATS,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_r;
    logic         at_last_s;

    assign at_last_s = (count_r == W'(MAX - 1));
    assign wrap      = inc && at_last_s;
    assign count     = count_r;

    // Beat position register with clear and terminal-count wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            if (at_last_s) begin
                count_r <= {W{1'b0}};
            end else begin
                count_r <= count_r + W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl
// Frame sequencer in front of the FFT stage pipeline. Groups upstream beats
// into BEATS-beat frames, feeds the pipeline a gap-free beat stream followed
// by FLUSH zero beats, and counts pipeline output valids to report frames.
//
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start, num_frames : arm a run of num_frames frames (0 runs one frame)
//   s_valid, s_ready  : upstream handshake; s_re/s_im upstream beat
//   p_valid, p_re/p_im: registered beat stream into the pipeline
//   p_valid_out       : valid from the last pipeline stage
//   frame_start       : first beat of each frame entering the pipeline
//   frame_done        : registered pulse after the BEATS-th output valid
//   busy              : sequencer not in IDLE
//   err_underrun      : sticky, upstream had no beat while streaming
//   err_timeout       : sticky DRAIN watchdog expiry
//
// Build option FFT_FRAME_CTRL_WDOG_EN: adds the DRAIN watchdog. Without it
// err_timeout is tied low and DRAIN waits for the last frame indefinitely.
// -----------------------------------------------------------------------------
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DATA  = 10,
    parameter int ARRAY = 16,
    parameter int BEATS = FFT_BEATS,
    parameter int FLUSH = FFT_FLUSH,
    parameter int WDOG  = FFT_WDOG
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [7:0]                         num_frames,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic signed [ARRAY-1:0][DATA-1:0]  s_re,
    input  logic signed [ARRAY-1:0][DATA-1:0]  s_im,
    output logic                               p_valid,
    output logic signed [ARRAY-1:0][DATA-1:0]  p_re,
    output logic signed [ARRAY-1:0][DATA-1:0]  p_im,
    input  logic                               p_valid_out,
    output logic                               frame_start,
    output logic                               frame_done,
    output logic                               busy,
    output logic                               err_underrun,
    output logic                               err_timeout
);

    localparam int BW = cnt_width(BEATS);
    localparam int FW = cnt_width(FLUSH);
    // The FLUSH parameter shadows the package state name inside this module.
    localparam fft_ctrl_state_t ST_FLUSH = fft_ctrl_pkg::FLUSH;

    fft_ctrl_state_t state_r;
    fft_ctrl_state_t next_state_s;

    logic [7:0]    count_r;
    logic [7:0]    frames_in_r;
    logic [7:0]    frames_out_r;
    logic [FW-1:0] flush_cnt_r;

    logic          start_acc_s;
    logic          in_inc_s;
    logic          in_wrap_s;
    logic [BW-1:0] in_beat_s;
    logic          out_inc_s;
    logic          out_wrap_s;
    logic [BW-1:0] out_beat_unused_s;
    logic          last_frame_s;
    logic          all_out_s;
    logic          wdog_hit_s;

    logic                              s_ready_r;
    logic                              busy_r;
    logic                              p_valid_r;
    logic [ARRAY-1:0][DATA-1:0]        p_re_r;
    logic [ARRAY-1:0][DATA-1:0]        p_im_r;
    logic                              frame_start_r;
    logic                              frame_done_r;
    logic                              err_underrun_r;

    assign start_acc_s  = (state_r == IDLE) && start;
    assign in_inc_s     = (state_r == STREAM);
    assign last_frame_s = ((frames_in_r + 8'd1) == count_r);
    assign all_out_s    = (frames_out_r == count_r);
    // Output valids count only while a run is active and frames remain.
    assign out_inc_s    = p_valid_out && (state_r != IDLE) && !all_out_s;

    fft_beat_counter #(.MAX(BEATS), .W(BW)) u_in_beat (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc_s),
        .inc   (in_inc_s),
        .count (in_beat_s),
        .wrap  (in_wrap_s)
    );

    // Only the wrap event of the output counter is needed here.
    fft_beat_counter #(.MAX(BEATS), .W(BW)) u_out_beat (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_acc_s),
        .inc   (out_inc_s),
        .count (out_beat_unused_s),
        .wrap  (out_wrap_s)
    );

`ifdef FFT_FRAME_CTRL_WDOG_EN
    localparam int WW = cnt_width(WDOG + 1);

    logic [WW-1:0] wdog_r;
    logic          err_timeout_r;

    // Expires on the DRAIN cycle whose increment would reach WDOG.
    assign wdog_hit_s = (state_r == DRAIN) && !p_valid_out && !all_out_s &&
                        (wdog_r == WW'(WDOG - 1));

    // DRAIN watchdog: zero outside DRAIN, restarted by any output valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_r <= {WW{1'b0}};
        end else if (state_r != DRAIN) begin
            wdog_r <= {WW{1'b0}};
        end else if (p_valid_out) begin
            wdog_r <= {WW{1'b0}};
        end else begin
            wdog_r <= wdog_r + WW'(1);
        end
    end

    // Sticky timeout flag, cleared by a new run.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout_r <= 1'b0;
        end else if (start_acc_s) begin
            err_timeout_r <= 1'b0;
        end else if (wdog_hit_s) begin
            err_timeout_r <= 1'b1;
        end else begin
            err_timeout_r <= err_timeout_r;
        end
    end

    assign err_timeout = err_timeout_r;
`else
    localparam int WDOG_UNUSED = WDOG;

    assign wdog_hit_s  = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state logic for the frame sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = STREAM;
                end else begin
                    next_state_s = IDLE;
                end
            end
            STREAM: begin
                if (in_wrap_s && last_frame_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = STREAM;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FW'(FLUSH - 1)) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            DRAIN: begin
                if (all_out_s) begin
                    next_state_s = IDLE;
                end else if (wdog_hit_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, run bookkeeping and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            count_r        <= 8'd0;
            frames_in_r    <= 8'd0;
            frames_out_r   <= 8'd0;
            flush_cnt_r    <= {FW{1'b0}};
            s_ready_r      <= 1'b0;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
            err_underrun_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            // Status registers track the state being entered so they line
            // up with state_r on every cycle.
            s_ready_r <= (next_state_s == STREAM);
            busy_r    <= (next_state_s != IDLE);

            if (start_acc_s) begin
                count_r <= (num_frames == 8'd0) ? 8'd1 : num_frames;
            end else begin
                count_r <= count_r;
            end

            if (start_acc_s) begin
                frames_in_r <= 8'd0;
            end else if (in_wrap_s) begin
                frames_in_r <= frames_in_r + 8'd1;
            end else begin
                frames_in_r <= frames_in_r;
            end

            if (start_acc_s) begin
                frames_out_r <= 8'd0;
            end else if (out_wrap_s) begin
                frames_out_r <= frames_out_r + 8'd1;
            end else begin
                frames_out_r <= frames_out_r;
            end
            frame_done_r <= out_wrap_s;

            if (state_r == ST_FLUSH) begin
                flush_cnt_r <= flush_cnt_r + FW'(1);
            end else begin
                flush_cnt_r <= {FW{1'b0}};
            end

            if (start_acc_s) begin
                err_underrun_r <= 1'b0;
            end else if ((state_r == STREAM) && !s_valid) begin
                err_underrun_r <= 1'b1;
            end else begin
                err_underrun_r <= err_underrun_r;
            end
        end
    end

    // Pipeline beat register: data while streaming, zeros while flushing.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_r     <= 1'b0;
            p_re_r        <= '0;
            p_im_r        <= '0;
            frame_start_r <= 1'b0;
        end else begin
            case (state_r)
                STREAM: begin
                    // A missing upstream beat still occupies a frame slot.
                    p_valid_r     <= 1'b1;
                    frame_start_r <= (in_beat_s == {BW{1'b0}});
                    if (s_valid) begin
                        p_re_r <= s_re;
                        p_im_r <= s_im;
                    end else begin
                        p_re_r <= '0;
                        p_im_r <= '0;
                    end
                end
                ST_FLUSH: begin
                    p_valid_r     <= 1'b1;
                    frame_start_r <= 1'b0;
                    p_re_r        <= '0;
                    p_im_r        <= '0;
                end
                default: begin
                    p_valid_r     <= 1'b0;
                    frame_start_r <= 1'b0;
                    p_re_r        <= '0;
                    p_im_r        <= '0;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_r;
    assign busy         = busy_r;
    assign p_valid      = p_valid_r;
    assign p_re         = p_re_r;
    assign p_im         = p_im_r;
    assign frame_start  = frame_start_r;
    assign frame_done   = frame_done_r;
    assign err_underrun = err_underrun_r;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_ctrl
// Directed bench for fft_frame_ctrl. A fixed-latency pipeline model returns
// p_valid as p_valid_out LAT cycles later, optionally capped to a number of
// returned beats; a negedge monitor tallies pulses and p_valid runs.
// -----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

    localparam int DATA  = 10;
    localparam int ARRAY = 16;
    localparam int BEATS = 32;
    localparam int FLUSH = 32;
    localparam int LAT   = 32;
    localparam int VW    = ARRAY * DATA;

    typedef logic signed [ARRAY-1:0][DATA-1:0] beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_frames = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    beat_t      s_re = '0;
    beat_t      s_im = '0;
    logic       p_valid;
    beat_t      p_re;
    beat_t      p_im;
    logic       p_valid_out;
    logic       frame_start;
    logic       frame_done;
    logic       busy;
    logic       err_underrun;
    logic       err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // pipeline model
    logic [63:0] pv_sh = 64'd0;
    int          delivered = 0;
    int          limit = 100000;
    logic        pipe_clr = 1'b1;

    // monitor
    logic mon_clr = 1'b1;
    int   fs_cnt = 0;
    int   fd_cnt = 0;
    int   pv_cnt = 0;
    int   pv_runs = 0;
    logic prev_pv = 1'b0;
    int   fs_idx [4];

    fft_frame_ctrl #(
        .DATA(DATA), .ARRAY(ARRAY), .BEATS(BEATS), .FLUSH(FLUSH), .WDOG(1023)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .p_valid(p_valid), .p_re(p_re), .p_im(p_im),
        .p_valid_out(p_valid_out), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy),
        .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    assign p_valid_out = pv_sh[LAT-1] && (delivered < limit);

    always @(posedge clk) begin
        if (pipe_clr) begin
            pv_sh     <= 64'd0;
            delivered <= 0;
        end else begin
            pv_sh <= {pv_sh[62:0], p_valid};
            if (p_valid_out) delivered <= delivered + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            fs_cnt  <= 0;
            fd_cnt  <= 0;
            pv_cnt  <= 0;
            pv_runs <= 0;
            prev_pv <= 1'b0;
            for (int i = 0; i < 4; i++) fs_idx[i] <= -1;
        end else begin
            if (frame_start) begin
                fs_cnt <= fs_cnt + 1;
                if (fs_cnt < 4) fs_idx[fs_cnt] <= pv_cnt;
            end
            if (frame_done) fd_cnt <= fd_cnt + 1;
            if (p_valid) pv_cnt <= pv_cnt + 1;
            if (p_valid && !prev_pv) pv_runs <= pv_runs + 1;
            prev_pv <= p_valid;
        end
    end

    function automatic beat_t mk_re(input int b);
        beat_t r;
        for (int k = 0; k < ARRAY; k++) r[k] = DATA'(b * 16 + k);
        return r;
    endfunction

    function automatic beat_t mk_im(input int b);
        beat_t r;
        for (int k = 0; k < ARRAY; k++) r[k] = DATA'(7 - b * 5 - k * 3);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int n);
        mon_clr  = 1'b1;
        pipe_clr = 1'b1;
        step();
        mon_clr  = 1'b0;
        pipe_clr = 1'b0;
        start      = 1'b1;
        num_frames = n[7:0];
        step();
        start = 1'b0;
        chk("busy_after_start", VW'(busy), VW'(1));
        chk("s_ready_after_start", VW'(s_ready), VW'(1));
    endtask

    task automatic stream(input int nb, input int under_b, input int start_at);
        for (int b = 0; b < nb; b++) begin
            if (b == start_at) begin
                start      = 1'b1;
                num_frames = 8'd5;
            end else begin
                start = 1'b0;
            end
            s_valid = (b != under_b);
            s_re    = mk_re(b);
            s_im    = mk_im(b);
            step();
            chk("p_valid_data", VW'(p_valid), VW'(1));
            chk("p_re", p_re, (b == under_b) ? VW'(0) : VW'(mk_re(b)));
            chk("p_im", p_im, (b == under_b) ? VW'(0) : VW'(mk_im(b)));
            chk("frame_start", VW'(frame_start), VW'((b % BEATS) == 0));
        end
        start   = 1'b0;
        s_valid = 1'b0;
        s_re    = '0;
        s_im    = '0;
    endtask

    task automatic flush_check();
        for (int i = 0; i < FLUSH; i++) begin
            step();
            chk("p_valid_flush", VW'(p_valid), VW'(1));
            chk("p_re_flush", p_re, VW'(0));
            chk("frame_start_flush", VW'(frame_start), VW'(0));
            chk("s_ready_flush", VW'(s_ready), VW'(0));
        end
        step();
        chk("p_valid_drain", VW'(p_valid), VW'(0));
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            step();
            i++;
        end
        chk("idle_reached", VW'(busy), VW'(0));
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_p_valid", VW'(p_valid), VW'(0));
        chk("rst_s_ready", VW'(s_ready), VW'(0));
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_frame_start", VW'(frame_start), VW'(0));
        chk("rst_frame_done", VW'(frame_done), VW'(0));
        chk("rst_err_underrun", VW'(err_underrun), VW'(0));
        chk("rst_err_timeout", VW'(err_timeout), VW'(0));
        chk("rst_p_re", p_re, VW'(0));
        chk("rst_p_im", p_im, VW'(0));
        rst = 1'b0;
        step();

        // single frame
        start_run(1);
        stream(32, -1, -1);
        chk("s_ready_end_1", VW'(s_ready), VW'(0));
        flush_check();
        wait_idle(200);
        chk("fd_cnt_1", VW'(fd_cnt), VW'(1));
        chk("fs_cnt_1", VW'(fs_cnt), VW'(1));
        chk("pv_cnt_1", VW'(pv_cnt), VW'(64));
        chk("pv_runs_1", VW'(pv_runs), VW'(1));
        chk("underrun_1", VW'(err_underrun), VW'(0));
        chk("timeout_1", VW'(err_timeout), VW'(0));

        // three frames, with an ignored start at beat 40
        start_run(3);
        stream(96, -1, 40);
        chk("s_ready_end_3", VW'(s_ready), VW'(0));
        flush_check();
        wait_idle(300);
        chk("fd_cnt_3", VW'(fd_cnt), VW'(3));
        chk("fs_cnt_3", VW'(fs_cnt), VW'(3));
        chk("fs_idx0", VW'(fs_idx[0]), VW'(0));
        chk("fs_idx1", VW'(fs_idx[1]), VW'(32));
        chk("fs_idx2", VW'(fs_idx[2]), VW'(64));
        chk("pv_cnt_3", VW'(pv_cnt), VW'(128));
        chk("pv_runs_3", VW'(pv_runs), VW'(1));

        // underrun at beat 10
        start_run(1);
        stream(32, 10, -1);
        chk("underrun_set", VW'(err_underrun), VW'(1));
        flush_check();
        wait_idle(200);
        chk("underrun_sticky", VW'(err_underrun), VW'(1));
        chk("fd_cnt_ur", VW'(fd_cnt), VW'(1));
        chk("pv_cnt_ur", VW'(pv_cnt), VW'(64));

        // reset at beat 17
        start_run(1);
        stream(17, 5, -1);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_re    = mk_re(17);
        step();
        rst     = 1'b0;
        s_valid = 1'b0;
        chk("mrst_p_valid", VW'(p_valid), VW'(0));
        chk("mrst_busy", VW'(busy), VW'(0));
        chk("mrst_s_ready", VW'(s_ready), VW'(0));
        chk("mrst_frame_start", VW'(frame_start), VW'(0));
        chk("mrst_frame_done", VW'(frame_done), VW'(0));
        chk("mrst_err_underrun", VW'(err_underrun), VW'(0));
        chk("mrst_p_re", p_re, VW'(0));
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
        repeat (50) step();
        chk("mrst_no_stale_done", VW'(fd_cnt), VW'(0));
        chk("mrst_idle", VW'(busy), VW'(0));
        start_run(1);
        stream(32, -1, -1);
        flush_check();
        wait_idle(200);
        chk("fd_cnt_after_rst", VW'(fd_cnt), VW'(1));
        chk("underrun_after_rst", VW'(err_underrun), VW'(0));

        // num_frames = 0 runs one frame
        start_run(0);
        stream(32, -1, -1);
        chk("s_ready_end_0", VW'(s_ready), VW'(0));
        flush_check();
        wait_idle(200);
        chk("fd_cnt_0", VW'(fd_cnt), VW'(1));
        chk("pv_cnt_0", VW'(pv_cnt), VW'(64));

        // output valids withheld after 31 beats
        limit = 31;
        start_run(1);
        stream(32, -1, -1);
        flush_check();
`ifdef FFT_FRAME_CTRL_WDOG_EN
        wait_idle(1200);
        chk("wdog_timeout", VW'(err_timeout), VW'(1));
        chk("wdog_no_done", VW'(fd_cnt), VW'(0));
`else
        repeat (200) step();
        chk("nowdog_busy", VW'(busy), VW'(1));
        chk("nowdog_no_done", VW'(fd_cnt), VW'(0));
        chk("nowdog_timeout", VW'(err_timeout), VW'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("nowdog_rst_idle", VW'(busy), VW'(0));
`endif
        limit = 100000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
